// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the fetch pc, reads imem combinationally, and queues {pc, instr} pairs for decode.
// Latency: a word fetched at edge N shows on out_* in cycle N+1. After a redirect at N, the target is valid in N+2.
// Backpressure: out_valid/out_ready handshake. When the FIFO is full, fetch stalls and fetch_pc/imem_address hold.
//
// Ports:
//   clock, reset                  single clock, synchronous active-high reset
//   imem_address/imem_data        fetch address out, instruction word back in the same cycle
//   imem_read_write               always 0, this port only reads
//   redirect_valid/redirect_pc    flush and restart request from execute, single-cycle pulse
//   out_valid/out_ready           head-of-FIFO handshake to decode
//   out_pc/out_instr              contents of the FIFO head
//   fault                         sticky misaligned-redirect flag
// Optional feature macro: FETCH_ALIGN_CHECK_EN.
//   Defined:   a misaligned redirect target raises fault and halts fetch until reset.
//   Undefined: the low two bits of the target are dropped and fault stays 0.

module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0100_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] imem_address,
    input  logic [31:0] imem_data,
    output logic        imem_read_write,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        fault
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [63:0]   mem_q [FIFO_DEPTH];
    logic [63:0]   mem_d [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          halted;
    logic          push;
    logic          pop;

`ifdef FETCH_ALIGN_CHECK_EN
    logic fault_q, fault_d;
    logic halted_q, halted_d;

    assign halted = halted_q;
    assign fault  = fault_q;
`else
    // Without the check, the low target bits are dropped, so they have no other reader.
    logic unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc[1:0];
    assign halted = 1'b0;
    assign fault  = 1'b0;
`endif

    assign imem_address    = fetch_pc_q;
    assign imem_read_write = 1'b0;
    assign out_valid       = (count_q != '0);
    assign out_pc          = mem_q[rd_ptr_q][63:32];
    assign out_instr       = mem_q[rd_ptr_q][31:0];

    // Fullness is sampled from count_q, so a pop in the same cycle does not
    // free a slot for this cycle's push.
    assign pop  = out_valid & out_ready;
    assign push = ~redirect_valid & (count_q != FULL_CNT) & ~halted;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        mem_d      = mem_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
`ifdef FETCH_ALIGN_CHECK_EN
        fault_d    = fault_q;
        halted_d   = halted_q;
`endif

        if (redirect_valid) begin
            // A flush discards this cycle's push and pop. Decode squashes any
            // handshake that completes alongside the redirect.
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
`ifdef FETCH_ALIGN_CHECK_EN
            fetch_pc_d = redirect_pc;
            if (redirect_pc[1:0] != 2'b00) begin
                fault_d  = 1'b1;
                halted_d = 1'b1;
            end
`else
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
`endif
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = {fetch_pc_q, imem_data};
                wr_ptr_d        = wr_ptr_q + PW'(1);
                fetch_pc_d      = fetch_pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
`ifdef FETCH_ALIGN_CHECK_EN
            fault_q  <= 1'b0;
            halted_q <= 1'b0;
`endif
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
`ifdef FETCH_ALIGN_CHECK_EN
            fault_q  <= fault_d;
            halted_q <= halted_d;
`endif
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, streaming, stall, redirect, wrap, misaligned target, reset priority.
// Inputs change 1 time unit after posedge, and outputs are sampled at the same point.
// The instruction memory is a fixed function of the address, so expected words are easy to derive by hand.

module tb_fetch_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] imem_address;
    logic [31:0] imem_data;
    logic        imem_read_write;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        fault;

    integer n_cmp = 0;
    integer n_err = 0;

    always #5 clock = ~clock;

    // Memory word for an address: low half-word moved to the top, upper half-word inverted.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {a[15:0], ~a[31:16]};
    endfunction

    assign imem_data = word_at(imem_address);

    fetch_stage dut (
        .clock          (clock),
        .reset          (reset),
        .imem_address   (imem_address),
        .imem_data      (imem_data),
        .imem_read_write(imem_read_write),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .fault          (fault)
    );

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        redirect_valid = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        out_ready = 1'b1;
        step();
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %h want 0", out_valid); end
        n_cmp++; if (out_pc !== 32'h0) begin n_err++; $display("FAIL reset_pc got %h want 00000000", out_pc); end
        n_cmp++; if (out_instr !== 32'h0) begin n_err++; $display("FAIL reset_instr got %h want 00000000", out_instr); end
        n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL reset_fault got %h want 0", fault); end
        n_cmp++; if (imem_address !== 32'h0100_0000) begin n_err++; $display("FAIL reset_addr got %h want 01000000", imem_address); end
        n_cmp++; if (imem_read_write !== 1'b0) begin n_err++; $display("FAIL reset_rw got %h want 0", imem_read_write); end
    endtask

    task automatic test_stream;
        logic [31:0] exp_pc;
        reset = 1'b0;
        exp_pc = 32'h0100_0000;
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++; if (out_valid !== 1'b1 || out_pc !== exp_pc || out_instr !== word_at(exp_pc)) begin
                n_err++; $display("FAIL stream[%0d] got v=%h pc=%h ins=%h want v=1 pc=%h ins=%h",
                                  i, out_valid, out_pc, out_instr, exp_pc, word_at(exp_pc));
            end
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] exp_pc;
        out_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step();
            if (i >= 1) begin
                n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h0100_0000) begin
                    n_err++; $display("FAIL stall_head[%0d] got v=%h pc=%h want v=1 pc=01000000", i, out_valid, out_pc);
                end
            end
        end
        n_cmp++; if (imem_address !== 32'h0100_0008) begin n_err++; $display("FAIL stall_addr got %h want 01000008", imem_address); end
        out_ready = 1'b1;
        exp_pc = 32'h0100_0004;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (out_valid !== 1'b1 || out_pc !== exp_pc || out_instr !== word_at(exp_pc)) begin
                n_err++; $display("FAIL drain[%0d] got v=%h pc=%h ins=%h want v=1 pc=%h ins=%h",
                                  i, out_valid, out_pc, out_instr, exp_pc, word_at(exp_pc));
            end
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    task automatic test_redirect;
        out_ready = 1'b0;
        do_reset();
        step(); step(); step();
        out_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0100_0040;
        step();
        redirect_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL redir_bubble got v=%h want 0", out_valid); end
        n_cmp++; if (imem_address !== 32'h0100_0040) begin n_err++; $display("FAIL redir_addr got %h want 01000040", imem_address); end
        step();
        n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h0100_0040 || out_instr !== word_at(32'h0100_0040)) begin
            n_err++; $display("FAIL redir_target got v=%h pc=%h ins=%h want v=1 pc=01000040", out_valid, out_pc, out_instr);
        end
        step();
        n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h0100_0044) begin
            n_err++; $display("FAIL redir_next got v=%h pc=%h want v=1 pc=01000044", out_valid, out_pc);
        end
    endtask

    task automatic test_wrap;
        out_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL wrap_bubble got v=%h want 0", out_valid); end
        step();
        n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'hFFFF_FFFC) begin
            n_err++; $display("FAIL wrap_top got v=%h pc=%h want v=1 pc=fffffffc", out_valid, out_pc);
        end
        step();
        n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'h0000_FFFF) begin
            n_err++; $display("FAIL wrap_zero got v=%h pc=%h ins=%h want v=1 pc=00000000 ins=0000ffff", out_valid, out_pc, out_instr);
        end
    endtask

    task automatic test_misaligned;
        out_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0100_0042;
        step();
        redirect_valid = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        n_cmp++; if (fault !== 1'b1) begin n_err++; $display("FAIL mis_fault got %h want 1", fault); end
        n_cmp++; if (imem_address !== 32'h0100_0042) begin n_err++; $display("FAIL mis_addr got %h want 01000042", imem_address); end
        for (int i = 0; i < 10; i++) begin
            step();
            n_cmp++; if (out_valid !== 1'b0 || fault !== 1'b1) begin
                n_err++; $display("FAIL mis_halt[%0d] got v=%h f=%h want v=0 f=1", i, out_valid, fault);
            end
        end
        do_reset();
        n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL mis_clear got %h want 0", fault); end
`else
        n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL mis_fault got %h want 0", fault); end
        step();
        n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h0100_0040) begin
            n_err++; $display("FAIL mis_align got v=%h pc=%h want v=1 pc=01000040", out_valid, out_pc);
        end
`endif
    endtask

    task automatic test_reset_override;
        out_ready = 1'b0;
        do_reset();
        step(); step(); step();
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL ovr_pre got v=%h want 1", out_valid); end
        reset = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0200_0000;
        step();
        reset = 1'b0;
        redirect_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ovr_valid got %h want 0", out_valid); end
        n_cmp++; if (imem_address !== 32'h0100_0000) begin n_err++; $display("FAIL ovr_addr got %h want 01000000", imem_address); end
        n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL ovr_fault got %h want 0", fault); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_misaligned();
        test_reset_override();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage that sits directly upstream of the instruction memory and feeds decode. It owns the fetch program counter and drives the memory address, which returns the instruction combinationally. It captures each {pc, instruction} pair into a small in-order FIFO and presents it to decode over a valid/ready handshake. Branch/jump redirects from execute flush the FIFO and restart fetch at the target.

## Interface
- RESET_PC, 32'h0100_0000, first fetch address after reset (instruction memory base)
- FIFO_DEPTH, 2, entries in the fetch FIFO; power of two, ≥ 2
- clock  in  1  single clock, all state updates on posedge
- reset  in  1  synchronous, active-high
- imem_address  out  32  fetch address to instruction memory, equals fetch_pc
- imem_data  in  32  instruction word returned combinationally for imem_address
- imem_read_write  out  1  constant 0 (read only)
- redirect_valid  in  1  redirect request from execute, single-cycle pulse
- redirect_pc  in  32  redirect target
- out_valid  out  1  FIFO head holds a valid entry
- out_ready  in  1  decode accepts the head this cycle
- out_pc  out  32  pc of FIFO head
- out_instr  out  32  instruction of FIFO head
- fault  out  1  sticky misaligned-redirect flag (see Configuration)

## Operation
- State: fetch_pc (32b), FIFO storage of FIFO_DEPTH × 64b, rd_ptr/wr_ptr (log2(FIFO_DEPTH) bits, wrap naturally), count (log2(FIFO_DEPTH)+1 bits).
- out_valid = (count != 0); out_pc/out_instr = entry at rd_ptr (combinational read of registered storage).
- pop = out_valid & out_ready.
- push = ~redirect_valid & (count != FIFO_DEPTH) & ~halted. Fullness is sampled at the start of the cycle, so there is no push into a full FIFO even when a pop occurs in the same cycle.
- On push: store {fetch_pc, imem_data} at wr_ptr, wr_ptr+1, fetch_pc <= fetch_pc + 4, computed mod 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
- count update: +1 on push only, −1 on pop only, unchanged on both or neither.
- Redirect has highest priority. When redirect_valid=1, count, rd_ptr and wr_ptr go to 0, and fetch_pc <= redirect_pc. Any pop or push in that cycle is discarded. A handshake that completes in the same cycle as the redirect is still taken by decode, and decode must squash it.
- Reset values: fetch_pc=RESET_PC, pointers/count=0, storage=0. So out_valid=0, out_pc=0, out_instr=0, fault=0, imem_address=RESET_PC.
- Reset asserted mid-stream overrides everything, including redirect.

## Timing
- Fetch-to-output latency is 1 cycle. A word pushed at edge N is visible on out_* after edge N, i.e. in cycle N+1.
- First instruction after reset deasserts: pushed at the first edge with reset=0; out_valid=1 in the next cycle.
- Redirect at cycle N: out_valid=0 in cycle N+1, when the target is fetched. The target instruction appears with out_valid=1 in cycle N+2.
- Sustained throughput is 1 instruction per cycle when out_ready=1 continuously, for FIFO_DEPTH ≥ 2.
- out_valid, once high, stays high with stable out_pc/out_instr until popped, redirect, or reset.

## Configuration
- FETCH_ALIGN_CHECK_EN defined: redirect_valid with redirect_pc[1:0] != 2'b00 sets fault=1 (sticky until reset) and sets halted. The flush still occurs, no further pushes occur, and out_valid stays 0 until reset. fetch_pc loads the raw target.
- Not defined: fetch_pc loads {redirect_pc[31:2], 2'b00}, fault is tied to 0, and halted is always 0.

## Test plan
- Reset release, out_ready=1 -> out_pc sequence 0x0100_0000, 0x0100_0004, 0x0100_0008… on consecutive cycles; out_instr matches memory words; out_valid first high 1 cycle after reset release.
- out_ready=0 for 6 cycles -> count saturates at 2, fetch_pc holds 0x0100_0008, imem_address stable. Release -> entries 0x0100_0000 then 0x0100_0004 with none skipped or duplicated.
- Redirect to 0x0100_0040 with FIFO full and out_ready=1 -> out_valid=0 next cycle, then out_pc=0x0100_0040; old entries never reappear.
- Redirect to 0xFFFF_FFFC -> out_pc 0xFFFF_FFFC then 0x0000_0000 (wrap).
- Redirect to 0x0100_0042: with FETCH_ALIGN_CHECK_EN, fault=1 and out_valid stays 0 for 10 cycles, then reset clears fault. Without the macro, out_pc=0x0100_0040.
- Reset asserted while FIFO holds 2 entries and redirect_valid=1 -> next cycle out_valid=0, imem_address=0x0100_0000, fault=0.
